sorted_reader: RTL and testbench
================================

# sorted_reader

Streams the contents of the sorter's result buffer out on a valid/ready interface. On a start pulse, it issues `len` sequential synchronous reads to the buffer, beginning at `base` and wrapping modulo `SIZE`. It pushes each returned word into a 3-entry output queue and emits the words in address order under backpressure. It is the read-side counterpart of the buffer write path and sits between the sort core's storage and the downstream consumer.

## Interface
- `SIZE`, 8: buffer depth in words (≥2, need not be a power of two); `AW = $clog2(SIZE)`.
- `WIDTH`, 8: data word width.

- `clk`  in  1  rising-edge clock.
- `rstn`  in  1  asynchronous, active-low reset.
- `start`  in  1  begin a read-out; sampled only in IDLE.
- `len`  in  AW+1  number of words to read; sampled with `start`.
- `base`  in  AW  first buffer address; sampled with `start`; must be < SIZE.
- `rd_en`  out  1  buffer read strobe.
- `rd_addr`  out  AW  buffer read address.
- `rd_data`  in  WIDTH  buffer data, valid the cycle after `rd_en`.
- `dout`  out  WIDTH  output word.
- `dout_valid`  out  1  `dout` holds a valid word.
- `dout_ready`  in  1  consumer accepts `dout`.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the final word is accepted.

## Operation
- FSM states: IDLE, RUN, FINISH.
- **IDLE:**
  - With `start`=1, latch `base` and the clamped length `n = min(len, SIZE)`.
  - Clear the issue counter `iss` and the accept counter `acc`.
  - If `n`=0, go to FINISH; otherwise go to RUN.
- **RUN:**
  - `rd_en = (iss < n) && (occ + infl < 3)`.
    - `occ` is the registered queue occupancy (0..3).
    - `infl` is a registered flag meaning a read was issued last cycle.
  - `rd_addr = (base + iss) mod SIZE`.
    - Wrap from SIZE−1 to 0, not at 2^AW.
    - Compute with AW+1 bits, then subtract SIZE if the result is ≥ SIZE.
  - Each `rd_en` cycle increments `iss`.
  - The cycle after `rd_en`, `rd_data` is written into the queue at the clock edge ending that cycle.
- **Queue:**
  - 3-entry FIFO; `dout` is the head entry.
  - `dout_valid = (occ != 0)`.
  - A handshake (`dout_valid && dout_ready`) pops the head.
  - Push and pop in the same cycle leave `occ` unchanged.
  - The credit rule guarantees the queue never overflows.
- Each handshake increments `acc`. When a handshake occurs with `acc = n−1`, go to FINISH.
- **FINISH:** `done`=1 for exactly one cycle, then go to IDLE.
- `start` in RUN or FINISH is ignored. `len` and `base` changes after the start cycle have no effect.
- `dout` holds its value while `dout_valid`=1 and `dout_ready`=0.

## Timing
- Reset values: `rd_en`=0, `rd_addr`=0, `dout`=0, `dout_valid`=0, `busy`=0, `done`=0. State is IDLE, the queue is empty, `infl`=0.
- Reset asserted mid-run aborts immediately: the queue is flushed, no `done` is produced, and any `rd_data` arriving after reset is discarded.
- `start` in cycle 0: `busy`=1 and first `rd_en` with `rd_addr`=`base` in cycle 1. Word 0 is on `dout` with `dout_valid` in cycle 3 (latency 3).
- With `dout_ready` held high, one word per cycle. Last word of `n` appears in cycle n+2, `done` in cycle n+3, `busy` low in cycle n+4. A new `start` is accepted in cycle n+4.
- `n`=0: `done` pulses in cycle 1 with `busy`=1 that cycle; no `rd_en`.
- Under backpressure, at most 3 words are outstanding (queued plus in-flight). `rd_en` resumes the cycle after a pop frees credit.

## Test plan
- SIZE=8, base=0, len=8, ready=1; buffer holds 7..0 → `rd_addr` 0..7 in cycles 1–8, `dout` 7,6,…,0 in cycles 3–10, `done` in cycle 11.
- base=6, len=4 → `rd_addr` 6,7,0,1; output order matches; no access to address 8.
- SIZE=6 (non-power-of-two), base=4, len=5 → `rd_addr` 4,5,0,1,2.
- len=0 → `done` in cycle 1, `rd_en` never asserted. len=12 with SIZE=8 → exactly 8 reads and 8 outputs.
- `dout_ready` low for cycles 3–10 → at most 3 reads issued, `dout` stable. After ready rises, all words delivered in order with no loss or duplication.
- `rstn` low in cycle 5 of a len=8 run → all outputs at reset values. A later `start` with base=2, len=3 → clean run producing words at addresses 2,3,4.

Source files
------------

// File: rtl/sorted_reader.sv
// ---------------------------------------------------------------------------
// sorted_reader
//
// Streams a window of the sorter's result buffer out on a valid/ready
// interface. A start pulse captures a base address and a length (clamped
// to SIZE). The block then issues sequential single-cycle reads to the
// buffer, wrapping modulo SIZE. Returned words land in a 3-entry FIFO that
// drives the consumer. Reads are credit-limited so that queued words plus
// the one read in flight never exceed the FIFO depth.
//
// Ports
//   clk         rising-edge clock
//   rstn        asynchronous active-low reset
//   start       begin a read-out (sampled only while idle)
//   len         number of words to read, clamped to SIZE (sampled with start)
//   base        first buffer address, < SIZE (sampled with start)
//   rd_en       buffer read strobe
//   rd_addr     buffer read address
//   rd_data     buffer read data, valid the cycle after rd_en
//   dout        output word (FIFO head)
//   dout_valid  dout holds a valid word
//   dout_ready  consumer accepts dout
//   busy        read-out in progress
//   done        one-cycle pulse after the final word is accepted
// ---------------------------------------------------------------------------
module sorted_reader #(
    parameter  int SIZE  = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(SIZE)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [AW:0]      len,
    input  logic [AW-1:0]    base,
    output logic             rd_en,
    output logic [AW-1:0]    rd_addr,
    input  logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             done
);

    localparam int             QDEPTH = 3;
    localparam logic [AW:0]    SIZE_W = (AW+1)'(SIZE);
    localparam logic [AW:0]    ONE_W  = (AW+1)'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t          state_reg, state_next;
    logic [AW:0]     n_reg, n_next;
    logic [AW:0]     iss_reg, iss_next;
    logic [AW:0]     acc_reg, acc_next;
    logic [AW-1:0]   base_reg, base_next;
    logic            infl_reg;

    logic [1:0]      occ_reg, occ_next;
    logic [1:0]      head_reg, head_next;
    logic [WIDTH-1:0] q_mem [0:QDEPTH-1];

    logic [AW:0]     len_clamped;
    logic [2:0]      pending;
    logic            credit_ok;
    logic            issue;
    logic [AW:0]     addr_sum;
    logic [AW:0]     addr_wrap;
    logic            push;
    logic            pop;
    logic [2:0]      tail_sum;
    logic [1:0]      tail_idx;
    logic [QDEPTH-1:0] wr_sel;

    // ------------------------------------------------------------------
    // Read issue: credit counts queued words plus the read whose data is
    // arriving this cycle, so a new read can never overflow the FIFO.
    // ------------------------------------------------------------------
    assign len_clamped = (len > SIZE_W) ? SIZE_W : len;
    assign pending     = {1'b0, occ_reg} + {2'b00, infl_reg};
    assign credit_ok   = (pending < 3'(QDEPTH));
    assign issue       = (state_reg == RUN) && (iss_reg < n_reg) && credit_ok;
    assign rd_en       = issue;

    // Wrap at SIZE rather than 2^AW so non-power-of-two depths work.
    assign addr_sum  = {1'b0, base_reg} + iss_reg;
    assign addr_wrap = (addr_sum >= SIZE_W) ? (addr_sum - SIZE_W) : addr_sum;
    assign rd_addr   = (state_reg == RUN) ? addr_wrap[AW-1:0] : '0;

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    assign push       = infl_reg;
    assign dout_valid = (occ_reg != 2'd0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = q_mem[head_reg];

    // Tail slot is computed from the pre-pop head, which is correct even
    // when a push and a pop share the cycle.
    assign tail_sum = {1'b0, head_reg} + {1'b0, occ_reg};
    assign tail_idx = (tail_sum >= 3'(QDEPTH)) ? 2'(tail_sum - 3'(QDEPTH)) : tail_sum[1:0];

    genvar gi;
    generate
        for (gi = 0; gi < QDEPTH; gi++) begin : g_wr_sel
            assign wr_sel[gi] = push && (tail_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        occ_next  = occ_reg;
        head_next = head_reg;
        case ({push, pop})
            2'b10:   occ_next = occ_reg + 2'd1;
            2'b01:   occ_next = occ_reg - 2'd1;
            default: occ_next = occ_reg;
        endcase
        if (pop) begin
            head_next = (head_reg == 2'(QDEPTH - 1)) ? 2'd0 : head_reg + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occ_reg  <= 2'd0;
            head_reg <= 2'd0;
            infl_reg <= 1'b0;
            for (int i = 0; i < QDEPTH; i++) begin
                q_mem[i] <= '0;
            end
        end else begin
            occ_reg  <= occ_next;
            head_reg <= head_next;
            infl_reg <= issue;
            for (int i = 0; i < QDEPTH; i++) begin
                if (wr_sel[i]) begin
                    q_mem[i] <= rd_data;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        n_next     = n_reg;
        base_next  = base_reg;
        iss_next   = iss_reg;
        acc_next   = acc_reg;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    n_next     = len_clamped;
                    base_next  = base;
                    iss_next   = '0;
                    acc_next   = '0;
                    state_next = (len_clamped == '0) ? FINISH : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (issue) begin
                    iss_next = iss_reg + ONE_W;
                end
                if (pop) begin
                    acc_next = acc_reg + ONE_W;
                    if (acc_reg == n_reg - ONE_W) begin
                        state_next = FINISH;
                    end
                end
            end
            FINISH: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
            n_reg     <= '0;
            base_reg  <= '0;
            iss_reg   <= '0;
            acc_reg   <= '0;
        end else begin
            state_reg <= state_next;
            n_reg     <= n_next;
            base_reg  <= base_next;
            iss_reg   <= iss_next;
            acc_reg   <= acc_next;
        end
    end

endmodule

// File: tb/tb_sorted_reader.sv
// ---------------------------------------------------------------------------
// tb_sorted_reader
//
// Self-checking bench for sorted_reader. Two instances: SIZE=8 (main
// directed and randomized runs) and SIZE=6 (non-power-of-two wrap).
// Each run's expected address sequence and output words are derived from
// the rule addr_i = (base + i) mod SIZE, i < min(len, SIZE).
// ---------------------------------------------------------------------------
module tb_sorted_reader;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SIZE=8 instance
    logic       start8 = 1'b0;
    logic [3:0] len8 = '0;
    logic [2:0] base8 = '0;
    logic       rd_en8;
    logic [2:0] rd_addr8;
    logic [7:0] rd_data8 = '0;
    logic [7:0] dout8;
    logic       dout_valid8;
    logic       dout_ready8 = 1'b0;
    logic       busy8;
    logic       done8;

    // SIZE=6 instance
    logic       start6 = 1'b0;
    logic [3:0] len6 = '0;
    logic [2:0] base6 = '0;
    logic       rd_en6;
    logic [2:0] rd_addr6;
    logic [7:0] rd_data6 = '0;
    logic [7:0] dout6;
    logic       dout_valid6;
    logic       dout_ready6 = 1'b0;
    logic       busy6;
    logic       done6;

    sorted_reader #(.SIZE(8), .WIDTH(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .len(len8), .base(base8),
        .rd_en(rd_en8), .rd_addr(rd_addr8), .rd_data(rd_data8),
        .dout(dout8), .dout_valid(dout_valid8), .dout_ready(dout_ready8),
        .busy(busy8), .done(done8)
    );

    sorted_reader #(.SIZE(6), .WIDTH(8)) dut6 (
        .clk(clk), .rstn(rstn), .start(start6), .len(len6), .base(base6),
        .rd_en(rd_en6), .rd_addr(rd_addr6), .rd_data(rd_data6),
        .dout(dout6), .dout_valid(dout_valid6), .dout_ready(dout_ready6),
        .busy(busy6), .done(done6)
    );

    // Buffer models with one-cycle registered read
    logic [7:0] mem8 [0:7];
    logic [7:0] mem6 [0:5];
    always @(posedge clk) if (rd_en8) rd_data8 <= mem8[rd_addr8];
    always @(posedge clk) if (rd_en6) rd_data6 <= (rd_addr6 < 3'd6) ? mem6[rd_addr6] : 8'hEE;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Monitor state for the SIZE=8 instance
    int addr_q[$];
    int out_q[$];
    int reads8, acc8, done_cnt8, first_rd8, first_vld8, done_cyc8, reads_at10;
    int run_c0 = 0;
    logic busy_at_done8;
    logic hold8 = 1'b0;
    logic [7:0] hold_val8 = '0;

    initial begin
        int rel;
        forever begin
            @(negedge clk);
            if (rstn) begin
                rel = cyc - run_c0;
                if (hold8) begin
                    check_value("hold_valid", dout_valid8, 1);
                    check_value("hold_data", dout8, hold_val8);
                end
                if (rd_en8) begin
                    reads8++;
                    addr_q.push_back(int'(rd_addr8));
                    if (first_rd8 < 0) first_rd8 = rel;
                    check_value("outstanding_le3", 32'((reads8 - acc8) <= 3), 1);
                end
                if (dout_valid8 && first_vld8 < 0) first_vld8 = rel;
                if (dout_valid8 && dout_ready8) begin
                    out_q.push_back(int'(dout8));
                    acc8++;
                end
                if (done8) begin
                    done_cnt8++;
                    done_cyc8 = rel;
                    busy_at_done8 = busy8;
                end
                if (rel == 10) reads_at10 = reads8;
                hold8     = dout_valid8 && !dout_ready8;
                hold_val8 = dout8;
            end else begin
                hold8 = 1'b0;
            end
        end
    end

    // Monitor state for the SIZE=6 instance
    int addr6_q[$];
    int out6_q[$];
    int done_cnt6;

    initial begin
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (rd_en6) begin
                    check_value("addr6_range", 32'(rd_addr6 < 3'd6), 1);
                    addr6_q.push_back(int'(rd_addr6));
                end
                if (dout_valid6 && dout_ready6) out6_q.push_back(int'(dout6));
                if (done6) done_cnt6++;
            end
        end
    end

    // mode 0: always ready, 1: random ready, 2: ready low in cycles 3..10
    function automatic logic ready_for(input int mode, input int rel);
        case (mode)
            0:       return 1'b1;
            1:       return ($urandom_range(0, 99) < 60);
            default: return !(rel >= 3 && rel <= 10);
        endcase
    endfunction

    task automatic clear_log8();
        addr_q.delete();
        out_q.delete();
        reads8 = 0; acc8 = 0; done_cnt8 = 0;
        first_rd8 = -1; first_vld8 = -1; done_cyc8 = -1; reads_at10 = -1;
        busy_at_done8 = 1'b0;
    endtask

    task automatic run8(input int b, input int l, input int mode, input bit desc);
        int n, rel, nchk;
        n = (l > 8) ? 8 : l;
        for (int i = 0; i < 8; i++) mem8[i] = desc ? 8'(7 - i) : 8'($urandom_range(0, 255));
        clear_log8();
        @(posedge clk); #1;
        run_c0 = cyc;
        start8 = 1'b1; base8 = 3'(b); len8 = 4'(l);
        dout_ready8 = ready_for(mode, 0);
        rel = 0;
        while (done_cnt8 == 0 && rel < 300) begin
            @(posedge clk); #1;
            rel++;
            // start/len/base noise while busy must be ignored
            start8 = 1'($urandom_range(0, 1));
            base8  = 3'($urandom_range(0, 7));
            len8   = 4'($urandom_range(0, 15));
            dout_ready8 = ready_for(mode, rel);
        end
        start8 = 1'b0;
        check_value("done_seen", done_cnt8, 1);
        check_value("busy_after_done", busy8, 0);
        check_value("busy_at_done", busy_at_done8, 1);
        check_value("num_reads", addr_q.size(), n);
        check_value("num_words", out_q.size(), n);
        nchk = (addr_q.size() < n) ? addr_q.size() : n;
        for (int i = 0; i < nchk; i++) check_value("rd_addr", addr_q[i], (b + i) % 8);
        nchk = (out_q.size() < n) ? out_q.size() : n;
        for (int i = 0; i < nchk; i++) check_value("dout", out_q[i], int'(mem8[(b + i) % 8]));
        if (mode == 0) begin
            check_value("done_cycle", done_cyc8, (n == 0) ? 1 : n + 3);
            if (n > 0) begin
                check_value("first_rd_cycle", first_rd8, 1);
                check_value("first_valid_cycle", first_vld8, 3);
            end
        end
        if (mode == 2) check_value("reads_during_stall", reads_at10, 3);
        $display("run8 base=%0d len=%0d mode=%0d reads=%0d words=%0d done_cyc=%0d", b, l, mode, addr_q.size(), out_q.size(), done_cyc8);
    endtask

    task automatic run6(input int b, input int l, input int mode);
        int n, rel, nchk;
        n = (l > 6) ? 6 : l;
        for (int i = 0; i < 6; i++) mem6[i] = 8'($urandom_range(0, 255));
        addr6_q.delete(); out6_q.delete(); done_cnt6 = 0;
        @(posedge clk); #1;
        start6 = 1'b1; base6 = 3'(b); len6 = 4'(l);
        dout_ready6 = ready_for(mode, 0);
        rel = 0;
        while (done_cnt6 == 0 && rel < 300) begin
            @(posedge clk); #1;
            rel++;
            start6 = 1'b0;
            dout_ready6 = ready_for(mode, rel);
        end
        check_value("done6_seen", done_cnt6, 1);
        check_value("num_reads6", addr6_q.size(), n);
        check_value("num_words6", out6_q.size(), n);
        nchk = (addr6_q.size() < n) ? addr6_q.size() : n;
        for (int i = 0; i < nchk; i++) check_value("rd_addr6", addr6_q[i], (b + i) % 6);
        nchk = (out6_q.size() < n) ? out6_q.size() : n;
        for (int i = 0; i < nchk; i++) check_value("dout6", out6_q[i], int'(mem6[(b + i) % 6]));
        $display("run6 base=%0d len=%0d mode=%0d reads=%0d words=%0d", b, l, mode, addr6_q.size(), out6_q.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check_value({tag, "_rd_en"}, rd_en8, 0);
        check_value({tag, "_rd_addr"}, rd_addr8, 0);
        check_value({tag, "_dout"}, dout8, 0);
        check_value({tag, "_dout_valid"}, dout_valid8, 0);
        check_value({tag, "_busy"}, busy8, 0);
        check_value({tag, "_done"}, done8, 0);
    endtask

    task automatic reset_abort();
        for (int i = 0; i < 8; i++) mem8[i] = 8'($urandom_range(0, 255));
        clear_log8();
        @(posedge clk); #1;
        run_c0 = cyc;
        start8 = 1'b1; base8 = 3'd0; len8 = 4'd8; dout_ready8 = 1'b1;
        repeat (5) begin
            @(posedge clk); #1;
            start8 = 1'b0;
        end
        rstn = 1'b0;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        repeat (3) @(negedge clk);
        check_value("abort_no_done", done_cnt8, 0);
        check_value("abort_flushed", dout_valid8, 0);
        check_value("abort_idle", busy8, 0);
        $display("reset_abort reads_before=%0d words_before=%0d", reads8, acc8);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 rstn = 1'b1;

        run8(0, 8, 0, 1'b1);    // descending contents, straight read-out
        run8(6, 4, 0, 1'b0);    // wrap 7 -> 0
        run8(0, 0, 0, 1'b0);    // empty request
        run8(3, 12, 0, 1'b0);   // len clamped to SIZE
        run8(0, 8, 2, 1'b0);    // backpressure window
        reset_abort();
        run8(2, 3, 0, 1'b0);    // clean run after abort
        run6(4, 5, 0);          // non-power-of-two wrap
        run6(5, 12, 1);

        for (int k = 0; k < 20; k++) begin
            run8($urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 1), 1'b0);
        end
        for (int k = 0; k < 5; k++) begin
            run6($urandom_range(0, 5), $urandom_range(0, 15), $urandom_range(0, 1));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
